// File: rtl/pingpong_buffer_if.sv
// Bus bundle for pingpong_buffer: write side, read side and bank status.
// master = producer/consumer pair that drives the buffer, slave = the buffer.
interface pingpong_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_done;
  logic                  wr_ready;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_done;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [1:0]            full_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    input  wr_ready, rd_ready, rd_data, rd_valid, full_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    output wr_ready, rd_ready, rd_data, rd_valid, full_cnt
  );
endinterface

// File: rtl/pingpong_buffer.sv
// Double-banked (ping-pong) buffer. The writer fills bank wbank while the
// reader drains bank rbank; ownership moves on wr_done / rd_done pulses.
// Optional macro PINGPONG_ERR_EN adds sticky protocol-violation flags
// (err[3:0]) with a clear input (err_clr).
module pingpong_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  pingpong_buffer_if.slave    bus
`ifdef PINGPONG_ERR_EN
  ,
  input  logic                err_clr,
  output logic [3:0]          err
`endif
);

  logic                  wbank;
  logic                  rbank;
  logic [1:0]            bank_full;
  logic                  wbank_nxt;
  logic                  rbank_nxt;
  logic [1:0]            bank_full_nxt;
  logic                  wr_ready;
  logic                  rd_ready;
  logic                  wr_acc;
  logic                  wr_hand;
  logic                  rd_acc;
  logic                  rd_rel;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  logic [DATA_WIDTH-1:0] mem [0:1][0:DEPTH-1];

  // Addresses at or above DEPTH do not map to storage.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  assign wr_ready = ~bank_full[wbank];
  assign rd_ready = bank_full[rbank];
  assign wr_acc   = bus.wr_en   & wr_ready;
  assign wr_hand  = bus.wr_done & wr_ready;
  assign rd_acc   = bus.rd_en   & rd_ready;
  assign rd_rel   = bus.rd_done & rd_ready;

  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;
  assign bus.full_cnt = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};
  assign bus.rd_data  = rd_data_p1;
  assign bus.rd_valid = vld_p1;

  // Next bank ownership: handover and release may coincide; they always
  // touch different banks since wr_ready and rd_ready exclude each other
  // whenever both pointers name the same bank.
  always_comb begin
    wbank_nxt     = wbank;
    rbank_nxt     = rbank;
    bank_full_nxt = bank_full;
    if (wr_hand) begin
      bank_full_nxt[wbank] = 1'b1;
      wbank_nxt            = ~wbank;
    end
    if (rd_rel) begin
      bank_full_nxt[rbank] = 1'b0;
      rbank_nxt            = ~rbank;
    end
  end

  // Ownership state register; reset empties both banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      wbank     <= wbank_nxt;
      rbank     <= rbank_nxt;
      bank_full <= bank_full_nxt;
    end
  end

  // Storage write into the current write bank (old wbank on a handover cycle).
  always_ff @(posedge clk) begin
    if (wr_acc && in_range(bus.wr_addr))
      mem[wbank][bus.wr_addr] <= bus.wr_data;
  end

  // Read stage p0 -> p1: one-cycle registered read from the current read bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc)
        rd_data_p1 <= in_range(bus.rd_addr) ? mem[rbank][bus.rd_addr] : '0;
    end
  end

`ifdef PINGPONG_ERR_EN
  logic [3:0] viol;
  logic [3:0] err_q;

  assign viol = {bus.rd_done & ~rd_ready, bus.rd_en & ~rd_ready,
                 bus.wr_done & ~wr_ready, bus.wr_en & ~wr_ready};
  assign err  = err_q;

  // Sticky violation flags; a new violation wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 4'b0000;
    else     err_q <= (err_clr ? 4'b0000 : err_q) | viol;
  end
`endif

endmodule

// File: tb/tb_pingpong_buffer.sv
// Directed bench for pingpong_buffer with hand-computed expectations.
module tb_pingpong_buffer;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  pingpong_buffer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

`ifdef PINGPONG_ERR_EN
  logic       err_clr;
  logic [3:0] err;
`endif

  pingpong_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .DEPTH(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef PINGPONG_ERR_EN
    ,
    .err_clr (err_clr),
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.wr_done = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  task automatic read1(input logic [5:0] a, input logic [15:0] exp, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    idle();
    chk({tag, "_data"}, bus.rd_data, exp);
    chk({tag, "_vld"},  bus.rd_valid, 1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
`ifdef PINGPONG_ERR_EN
    err_clr = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_full_cnt", bus.full_cnt, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data",  bus.rd_data, 0);

`ifdef PINGPONG_ERR_EN
    chk("err_rst", err, 4'b0000);
    bus.rd_en = 1'b1;
    tick();
    idle();
    chk("err_rd_illegal", err, 4'b0100);
    chk("err_rd_vld", bus.rd_valid, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", err, 4'b0000);
`endif

    // Fill bank 0
    for (int a = 0; a < 64; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'(a);
      bus.wr_data = 16'h1000 + 16'(a);
      tick();
    end
    idle();
    bus.wr_done = 1'b1;
    tick();
    idle();
    chk("b0_rd_ready", bus.rd_ready, 1);
    chk("b0_full_cnt", bus.full_cnt, 1);
    chk("b0_wr_ready", bus.wr_ready, 1);

    read1(6'd5, 16'h1005, "rd_b0_a5");
    tick();
    chk("rd_vld_drop", bus.rd_valid, 0);
    chk("rd_data_hold", bus.rd_data, 16'h1005);

    // Fill bank 1 while draining bank 0
    for (int a = 0; a < 64; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'(a);
      bus.wr_data = 16'h2000 + 16'(a);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'(63 - a);
      tick();
      chk("overlap_rd", bus.rd_data, 16'h1000 + 16'(63 - a));
    end
    idle();
    bus.wr_done = 1'b1;
    tick();
    idle();
    chk("both_full_cnt", bus.full_cnt, 2);
    chk("both_wr_ready", bus.wr_ready, 0);
    chk("both_rd_ready", bus.rd_ready, 1);

    // Illegal write and handover while both banks are full
    bus.wr_en   = 1'b1;
    bus.wr_addr = 6'd0;
    bus.wr_data = 16'hDEAD;
    bus.wr_done = 1'b1;
    tick();
    idle();
    chk("ill_full_cnt", bus.full_cnt, 2);
    chk("ill_wr_ready", bus.wr_ready, 0);
`ifdef PINGPONG_ERR_EN
    chk("err_wr_illegal", err, 4'b0011);
`endif

    // Read together with release: old bank, DEAD must not have landed
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'd0;
    bus.rd_done = 1'b1;
    tick();
    idle();
    chk("rel_rd_data", bus.rd_data, 16'h1000);
    chk("rel_rd_vld",  bus.rd_valid, 1);
    chk("rel_full_cnt", bus.full_cnt, 1);
    chk("rel_wr_ready", bus.wr_ready, 1);
    chk("rel_rd_ready", bus.rd_ready, 1);

    read1(6'd0,  16'h2000, "rd_b1_a0");
    read1(6'd63, 16'h203F, "rd_b1_a63");

    // Simultaneous handover and release, with a write in the same cycle
    bus.wr_en   = 1'b1;
    bus.wr_addr = 6'd7;
    bus.wr_data = 16'h3007;
    bus.wr_done = 1'b1;
    bus.rd_done = 1'b1;
    tick();
    idle();
    chk("sim_full_cnt", bus.full_cnt, 1);
    chk("sim_wr_ready", bus.wr_ready, 1);
    chk("sim_rd_ready", bus.rd_ready, 1);
    read1(6'd7, 16'h3007, "sim_rd_a7");
    read1(6'd0, 16'h1000, "sim_rd_a0");

    // Partial fill of bank 1, then asynchronous reset between edges
    for (int a = 0; a < 10; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'(a);
      bus.wr_data = 16'h4000 + 16'(a);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'd7;
      tick();
    end
    idle();
    chk("pre_rst_vld",  bus.rd_valid, 1);
    chk("pre_rst_data", bus.rd_data, 16'h3007);
    rst = 1'b1;
    #2;
    chk("arst_full_cnt", bus.full_cnt, 0);
    chk("arst_wr_ready", bus.wr_ready, 1);
    chk("arst_rd_ready", bus.rd_ready, 0);
    chk("arst_rd_valid", bus.rd_valid, 0);
    chk("arst_rd_data",  bus.rd_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Read with no full bank is ignored
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'd1;
    tick();
    idle();
    chk("ign_rd_vld",  bus.rd_valid, 0);
    chk("ign_rd_data", bus.rd_data, 0);
`ifdef PINGPONG_ERR_EN
    chk("err_after_rst", err, 4'b0100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
